// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, redirect flushes,
// and a saturating count of stalled cycles for the ID-stage pipeline registers.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_use,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [2:0]       id_exe_write,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MD_CNT_W = $clog2(MD_LATENCY);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [MD_CNT_W-1:0] md_cnt;
  logic [MD_CNT_W-1:0] md_cnt_nxt;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic lu;
  logic mds;
  logic md_last;
  logic md_issue;
  logic stall;

  // Hazard terms, all evaluated against the current cycle's ID/EXE contents
  always_comb begin
    md_last  = (state == MD_BUSY) && (md_cnt == '0);
    lu       = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mds      = (state == MD_BUSY) && id_md_use && !md_last;
    md_issue = id_md_start && !ex_redirect && !lu &&
               ((state == IDLE) || md_last);
    stall    = !ex_redirect && (lu || mds);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // A redirect never aborts a running mult/div; only reset does
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (md_issue) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        if (md_issue) begin
          md_cnt_nxt = MD_CNT_W'(MD_LATENCY - 1);
        end else if (md_last) begin
          state_nxt = IDLE;
        end else begin
          md_cnt_nxt = md_cnt - MD_CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Write-enables are held low for as long as reset is asserted
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_write = 3'b000;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (!reset) begin
      md_busy = (state == MD_BUSY);
      md_done = md_last;
      if (ex_redirect) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
      end else if (!(lu || mds)) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_exe_write = 3'b111;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a cycle-indexed reference model queues
// expected outputs, and a negedge monitor compares them with the DUT.
module tb_hazard_stall_ctrl;

  localparam int unsigned L     = 4;
  localparam int unsigned CNT_W = 16;
  localparam int          SAT   = (1 << CNT_W) - 1;
  localparam int          EXP_W = CNT_W + 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, id_md_start = 1'b0, id_md_use = 1'b0;
  logic             ex_mem_read = 1'b0, ex_redirect = 1'b0;
  logic             pc_write, if_id_write, if_id_flush, md_busy, md_done;
  logic [2:0]       id_exe_write;
  logic [CNT_W-1:0] stall_cnt;

  hazard_stall_ctrl #(.MD_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .id_md_use(id_md_use),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_exe_write(id_exe_write), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  logic [EXP_W-1:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               mon_cycle = 0;

  // Reference model state: the mult/div is busy in cycles issue_n+1 .. issue_n+L
  int n = 0;
  int issue_n = 0;
  bit md_act = 0;
  int scnt = 0;

  task automatic model_step();
    logic [EXP_W-1:0] e;
    bit busy, done, lu, mds;
    e = '0;
    if (reset) begin
      md_act = 0;
      scnt   = 0;
    end else begin
      busy = md_act && (n > issue_n) && (n <= issue_n + int'(L));
      done = busy && (n == issue_n + int'(L));
      lu   = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      mds  = busy && id_md_use && !done;
      e[CNT_W-1:0]   = CNT_W'(scnt);
      e[CNT_W]       = done;
      e[CNT_W+1]     = busy;
      if (ex_redirect)    e[CNT_W+7:CNT_W+2] = 6'b111_000;
      else if (lu || mds) e[CNT_W+7:CNT_W+2] = 6'b000_000;
      else                e[CNT_W+7:CNT_W+2] = 6'b110_111;
      if (!ex_redirect && (lu || mds) && scnt < SAT) scnt++;
      if (id_md_start && !ex_redirect && !lu && (!busy || done)) begin
        issue_n = n;
        md_act  = 1;
      end
    end
    n++;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic redir, input logic mr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic st, input logic use_md);
    @(posedge clock);
    #1;
    reset = rst; ex_redirect = redir; ex_mem_read = mr; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_md_start = st; id_md_use = use_md;
    model_step();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 1, 2, 0, 0, 0);
  endtask

  // Monitor: compare whatever the model queued for this cycle
  always @(negedge clock) begin
    logic [EXP_W-1:0] act, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_write, if_id_write, if_id_flush, id_exe_write, md_busy, md_done, stall_cnt};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle %0d outputs {pc,ifid_w,flush,idexe,busy,done,cnt}: got %h expected %h",
                 mon_cycle, act, e);
      end
      mon_cycle++;
    end
  end

  initial begin
    // Reset held: all enables low
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 8, 8, 0, 0, 1, 1);
    idle(2);

    // Load-use on rs, then on rt, then rt not used, then ex_rt == 0
    step(0, 0, 1, 8, 8, 3, 0, 0, 0);
    step(0, 0, 0, 0, 8, 3, 0, 0, 0);
    step(0, 0, 1, 9, 3, 9, 1, 0, 0);
    step(0, 0, 1, 9, 3, 9, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0, 0);
    idle(1);

    // mult then mflo waiting for completion, then back-to-back mult
    step(0, 0, 0, 0, 4, 5, 1, 1, 1);
    for (int i = 0; i < int'(L) + 2; i++) step(0, 0, 0, 0, 4, 5, 0, 0, 1);
    step(0, 0, 0, 0, 4, 5, 1, 1, 1);
    step(0, 0, 0, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < int'(L) + 1; i++) step(0, 0, 0, 0, 4, 5, 1, 1, 1);
    idle(int'(L) + 1);

    // Redirect overrides load-use; redirect during mult/div does not abort it
    step(0, 1, 1, 8, 8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0, 1, 1);
    step(0, 1, 0, 0, 1, 2, 0, 0, 1);
    step(0, 1, 0, 0, 1, 2, 0, 1, 1);
    idle(int'(L) + 1);

    // Reset asserted while the mult/div counter is mid-way
    step(0, 0, 0, 0, 1, 2, 0, 1, 1);
    idle(1);
    step(1, 0, 0, 0, 1, 2, 0, 0, 1);
    step(1, 0, 0, 0, 1, 2, 0, 0, 1);
    step(0, 0, 0, 0, 1, 2, 0, 0, 1);
    idle(2);

    // Randomized traffic with small register numbers to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(int'(L) + 1);

    // Long load-use stall to saturate the stall counter
    for (int i = 0; i < 66000; i++) step(0, 0, 1, 7, 7, 0, 0, 0, 0);
    idle(3);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
